regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the 16x32 single-write / dual-read register file.
- Provides DEPTH x DATA_W storage with two write ports, two read ports and registered reads with write-to-read bypass.
- Tracks a per-register "written since reset" flag.
- Used as the general-purpose register bank of the datapath; one clock domain.

Parameters:
DATA_W, 32, width of each register and of all data ports
ADDR_W, 4, select width; DEPTH = 2**ADDR_W (local, derived, not overridable)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
en  input  1  global enable; when 0 no state changes except reset
we_a  input  1  write enable, port A
sel_wa  input  ADDR_W  write address, port A
din_a  input  DATA_W  write data, port A
we_b  input  1  write enable, port B
sel_wb  input  ADDR_W  write address, port B
din_b  input  DATA_W  write data, port B
rd  input  1  read request for both read ports
sel_o1  input  ADDR_W  read address, port 1
sel_o2  input  ADDR_W  read address, port 2
dout1  output  DATA_W  registered read data, port 1
dout2  output  DATA_W  registered read data, port 2
init1  output  1  register read on port 1 has been written since reset
init2  output  1  register read on port 2 has been written since reset
rd_valid  output  1  dout1/dout2/init1/init2 updated by a read in the previous cycle

Behaviour:
- Single clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset: every register = 0, every written flag = 0, dout1 = dout2 = 0, init1 = init2 = 0, rd_valid = 0. Reset overrides en, we_a, we_b and rd in the same cycle.
- en = 0: no writes, written flags unchanged, dout*/init* hold, rd_valid = 0 next cycle.
- Write, en = 1:
  - we_a = 1: mem[sel_wa] <= din_a and flag[sel_wa] <= 1.
  - Port B behaves the same way.
  - we_a = we_b = 1 with sel_wa == sel_wb: port A wins; din_b is dropped.
  - Different addresses: both writes land in the same cycle.
- Read, en = 1 and rd = 1: dout1, init1 and dout2, init2 load on this edge; rd_valid = 1 on the next cycle. Latency is 1 cycle.
- Bypass: if sel_o1 matches an address being written in the same cycle, dout1 returns the new write data (port A value when both ports target it) and init1 = 1. Port 2 is identical. Reads never return stale data for a same-cycle write.
- rd = 0 (en = 1): dout*/init* hold previous values, rd_valid = 0.
- Back-to-back reads every cycle are supported; rd_valid stays high.
- rst asserted mid-stream: the next cycle shows the reset values; a read issued in the reset cycle is discarded.
- Unwritten registers read 0 with init = 0.
- Storage is flip-flop based, no inference of RAM with read-during-write ambiguity.

Optional Feature:
REGFILE_ZERO_REG_EN
- Defined:
  - Register 0 is hardwired: writes to address 0 on either port are ignored.
  - When sel_wa == 0 and we_b targets 0, port A has no write effect, so no priority win.
  - A read of address 0 returns 0 with init = 1.
  - Bypass never applies to address 0.
- Undefined: address 0 is an ordinary register.

Test Plan:
- Reset for 5 cycles, then en = 1, rd = 1, sel_o1 = 0, sel_o2 = 1 -> dout1 = dout2 = 0, init1 = init2 = 0, rd_valid = 1 one cycle after rd.
- we_a, sel_wa = 0, din_a = 0xABCDEFAB; next cycle we_b, sel_wb = 1, din_b = 0x01234567; then rd with sel_o1 = 0, sel_o2 = 1 -> dout1 = 0xABCDEFAB, dout2 = 0x01234567, init1 = init2 = 1.
- Collision: we_a = we_b = 1 on address 5, din_a = 0x11111111, din_b = 0x22222222 -> a later read of 5 returns 0x11111111.
- Bypass: same cycle we_a on address 3 = 0xDEADBEEF and rd sel_o1 = 3 -> dout1 = 0xDEADBEEF next cycle, init1 = 1.
- en = 0 while we_a on address 2 = 0x5A5A5A5A and rd = 1 -> no write (later read of 2 = 0, init = 0), rd_valid = 0, dout* hold.
- With REGFILE_ZERO_REG_EN: write 0xFFFFFFFF to address 0, read 0 -> dout1 = 0, init1 = 1. Then rst mid-stream after writes -> all reads return 0, init = 0.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: DEPTH x DATA_W register file, two write ports (A has priority),
// two registered read ports with same-cycle write-to-read bypass, and a
// per-register "written since reset" flag reported alongside read data.
//
// Optional feature macro: REGFILE_ZERO_REG_EN
//   defined   -> register 0 is hardwired to zero and reads back with init = 1
//   undefined -> register 0 is an ordinary register
//
// Handshake: a read is requested by rd = 1 while en = 1 (and rst = 0); the
// outputs dout*/init* load on that edge and rd_valid is 1 for exactly the
// following cycle. There is no backpressure; outputs hold when no read occurs.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] sel_wa,
    input  logic [DATA_W-1:0] din_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] sel_wb,
    input  logic [DATA_W-1:0] din_b,
    input  logic              rd,
    input  logic [ADDR_W-1:0] sel_o1,
    input  logic [ADDR_W-1:0] sel_o2,
    output logic [DATA_W-1:0] dout1,
    output logic [DATA_W-1:0] dout2,
    output logic              init1,
    output logic              init2,
    output logic              rd_valid
);

    localparam int DEPTH = 2 ** ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  flag_q, flag_d;
    logic [DATA_W-1:0] dout1_q, dout1_d;
    logic [DATA_W-1:0] dout2_q, dout2_d;
    logic              init1_q, init1_d;
    logic              init2_q, init2_d;
    logic              rd_valid_q, rd_valid_d;

    logic              wa_eff, wb_eff, rd_eff;
    logic [DATA_W-1:0] rdata1, rdata2;
    logic              rinit1, rinit2;

    // Effective write strobes: a write to the hardwired register has no
    // effect, so it cannot win priority over port B.
    always_comb begin
        wa_eff = en && we_a && !(ZERO_REG && (sel_wa == '0));
        wb_eff = en && we_b && !(ZERO_REG && (sel_wb == '0))
                 && !(wa_eff && (sel_wb == sel_wa));
        rd_eff = en && rd;
    end

    // Next storage state; port A is applied last so it wins a collision.
    always_comb begin
        mem_d  = mem_q;
        flag_d = flag_q;
        if (wb_eff) begin
            mem_d[sel_wb]  = din_b;
            flag_d[sel_wb] = 1'b1;
        end
        if (wa_eff) begin
            mem_d[sel_wa]  = din_a;
            flag_d[sel_wa] = 1'b1;
        end
    end

    // Reads look at next-state storage, which gives the write-to-read bypass.
    always_comb begin
        rdata1 = mem_d[sel_o1];
        rinit1 = flag_d[sel_o1];
        rdata2 = mem_d[sel_o2];
        rinit2 = flag_d[sel_o2];
        if (ZERO_REG && (sel_o1 == '0)) begin
            rdata1 = '0;
            rinit1 = 1'b1;
        end
        if (ZERO_REG && (sel_o2 == '0)) begin
            rdata2 = '0;
            rinit2 = 1'b1;
        end
    end

    // Read output registers load only on a granted read, otherwise hold.
    always_comb begin
        dout1_d    = rd_eff ? rdata1 : dout1_q;
        dout2_d    = rd_eff ? rdata2 : dout2_q;
        init1_d    = rd_eff ? rinit1 : init1_q;
        init2_d    = rd_eff ? rinit2 : init2_q;
        rd_valid_d = rd_eff;
    end

    // State update with synchronous reset overriding every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            flag_q     <= '0;
            dout1_q    <= '0;
            dout2_q    <= '0;
            init1_q    <= 1'b0;
            init2_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            flag_q     <= flag_d;
            dout1_q    <= dout1_d;
            dout2_q    <= dout2_d;
            init1_q    <= init1_d;
            init2_q    <= init2_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign dout1    = dout1_q;
    assign dout2    = dout2_q;
    assign init1    = init1_q;
    assign init2    = init2_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp. A reference model of the
// storage computes each read result when the read is driven and pushes it to
// exp_q; entries are popped and compared when the DUT raises rd_valid.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int OUT_W  = 2 * DATA_W + 2;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, en, we_a, we_b, rd;
    logic [ADDR_W-1:0] sel_wa, sel_wb, sel_o1, sel_o2;
    logic [DATA_W-1:0] din_a, din_b;
    logic [DATA_W-1:0] dout1, dout2;
    logic              init1, init2, rd_valid;

    // scoreboard: {init2, init1, dout2, dout1}
    logic [OUT_W-1:0]  exp_q[$];
    logic [OUT_W-1:0]  cur_exp;
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic [DEPTH-1:0]  m_flag;
    int                n_tests = 0;
    int                n_fail  = 0;

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .we_a(we_a), .sel_wa(sel_wa), .din_a(din_a),
        .we_b(we_b), .sel_wb(sel_wb), .din_b(din_b),
        .rd(rd), .sel_o1(sel_o1), .sel_o2(sel_o2),
        .dout1(dout1), .dout2(dout2), .init1(init1), .init2(init2),
        .rd_valid(rd_valid)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model read result {init, data} for one port, given this cycle's writes.
    function automatic logic [DATA_W:0] model_rd(input logic [ADDR_W-1:0] s,
                                                 input logic wa, input logic wb);
        if (ZERO && s == '0)           return {1'b1, {DATA_W{1'b0}}};
        if (wa && s == sel_wa)         return {1'b1, din_a};
        if (wb && s == sel_wb)         return {1'b1, din_b};
        return {m_flag[s], m_mem[s]};
    endfunction

    // Drive one cycle, update the model at the edge, then check outputs.
    task automatic step(input logic r, input logic e,
                        input logic wea, input logic [ADDR_W-1:0] swa, input logic [DATA_W-1:0] da,
                        input logic web, input logic [ADDR_W-1:0] swb, input logic [DATA_W-1:0] db,
                        input logic rdi, input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2);
        logic wa, wb, exp_rv;
        logic [DATA_W:0] p1, p2;
        rst = r; en = e; we_a = wea; sel_wa = swa; din_a = da;
        we_b = web; sel_wb = swb; din_b = db; rd = rdi; sel_o1 = s1; sel_o2 = s2;
        wa = e && wea && !(ZERO && swa == '0);
        wb = e && web && !(ZERO && swb == '0) && !(wa && swb == swa);
        exp_rv = !r && e && rdi;
        if (exp_rv) begin
            p1 = model_rd(s1, wa, wb);
            p2 = model_rd(s2, wa, wb);
            exp_q.push_back({p2[DATA_W], p1[DATA_W], p2[DATA_W-1:0], p1[DATA_W-1:0]});
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_flag  = '0;
            cur_exp = '0;
            exp_q.delete();
        end else begin
            if (wb) begin m_mem[swb] = db; m_flag[swb] = 1'b1; end
            if (wa) begin m_mem[swa] = da; m_flag[swa] = 1'b1; end
        end
        #1;
        check("rd_valid", rd_valid, exp_rv);
        if (rd_valid) begin
            if (exp_q.size() == 0) check("sb_underflow", 1, 0);
            else cur_exp = exp_q.pop_front();
        end
        check("rdata", {init2, init1, dout2, dout1}, cur_exp);
    endtask

    task automatic idle();
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_flag  = '0;
        cur_exp = '0;

        // reset 5 cycles, with writes and a read that must be discarded
        for (int i = 0; i < 5; i++) step(1, 1, 1, 4'd7, 32'hCAFE0000, 1, 4'd8, 32'h0BAD0000, 1, 7, 8);
        check("reset_state", {rd_valid, init2, init1, dout2, dout1}, 0);

        // unwritten registers read 0, init 0 (address 0 reads init=1 when hardwired)
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        check("first_read", {rd_valid, init2, init1, dout2, dout1},
              {1'b1, 1'b0, ZERO, 64'h0});

        // write A to 0, B to 1, then read both
        step(0, 1, 1, 0, 32'hABCDEFAB, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 1, 32'h01234567, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        check("rd_0_1", {init2, init1, dout2, dout1},
              {2'b11, 32'h01234567, ZERO ? 32'h0 : 32'hABCDEFAB});

        // collision on address 5: port A wins
        step(0, 1, 1, 5, 32'h11111111, 1, 5, 32'h22222222, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 5, 5);
        check("collision", {init1, dout1}, {1'b1, 32'h11111111});

        // collision with simultaneous read: bypass returns port A value
        step(0, 1, 1, 9, 32'h99999999, 1, 9, 32'h88888888, 1, 9, 9);

        // bypass: write 3 and read 3 in the same cycle
        step(0, 1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 1, 3, 5);
        check("bypass", {init1, dout1}, {1'b1, 32'hDEADBEEF});
        // bypass on port B, port 2
        step(0, 1, 0, 0, 0, 1, 6, 32'h66666666, 1, 4, 6);

        // en = 0: nothing written, outputs hold, rd_valid low
        step(0, 0, 1, 2, 32'h5A5A5A5A, 1, 4, 32'h44444444, 1, 2, 4);
        check("en0_hold", {rd_valid, dout2}, {1'b0, 32'h66666666});
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 4);
        check("en0_nowrite", {init2, init1, dout2, dout1}, 0);

        // rd = 0 holds, then back-to-back reads
        idle();
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 1, 4'(i), 4'(i + 3));

        // write all-ones to address 0, read it back
        step(0, 1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        check("addr0", {init1, dout1}, {1'b1, ZERO ? 32'h0 : 32'hFFFFFFFF});

        // port A write to 0 under hardwiring does not block port B to 0
        step(0, 1, 1, 0, 32'h12345678, 1, 0, 32'h87654321, 1, 0, 3);

        // mid-stream reset after writes: everything reads back as unwritten
        step(1, 1, 1, 3, 32'h33333333, 0, 0, 0, 1, 3, 3);
        check("mid_reset", {rd_valid, init2, init1, dout2, dout1}, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 5);
        check("post_reset_rd", {init2, init1, dout2, dout1}, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, DEPTH - 1)), $urandom,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, DEPTH - 1)), $urandom,
                 $urandom_range(0, 3) != 0,
                 4'($urandom_range(0, DEPTH - 1)), 4'($urandom_range(0, DEPTH - 1)));
        end
        idle();
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
